psola_playback_buffer: RTL and testbench

//  Consumer side of the PSOLA window output stream. Captures each burst of processed samples
//  (value, address, valid, done) into one of two ping-pong banks. Replays finished banks
//  one sample per audio-rate tick, giving a continuous stream to the DAC/I2S transmitter.

---
 rtl/psola_playback_buffer_pkg.sv | 21 ++
 rtl/psola_playback_buffer_if.sv | 28 ++
 rtl/pipeline.sv | 25 ++
 rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv | 52 +++++
 rtl/psola_playback_buffer.sv | 141 ++++++++++++++
 tb/tb_psola_playback_buffer.sv | 198 +++++++++++++++++++
 6 files changed

// File: rtl/psola_playback_buffer_pkg.sv
// Shared constants and types for the PSOLA playback buffer: window geometry,
// sample width, read-FSM state encoding and the bank/offset address helper.
package psola_pkg;

  localparam int MAX_EXTENDED = 2200;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = $clog2(MAX_EXTENDED);
  localparam int MEM_ADDR_W   = $clog2(2 * MAX_EXTENDED);

  typedef logic [ADDR_W-1:0] win_addr_t;
  typedef logic [0:0]        rd_state_t;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;

  // Bank 0 occupies the low MAX_EXTENDED words, bank 1 the next MAX_EXTENDED.
  function automatic logic [MEM_ADDR_W-1:0] mem_addr(input logic bank, input win_addr_t offs);
    return MEM_ADDR_W'(offs) + (bank ? MEM_ADDR_W'(MAX_EXTENDED) : '0);
  endfunction

endpackage

// File: rtl/psola_playback_buffer_if.sv
// Window-stream input and playback-stream output of the playback buffer.
// win_valid_in qualifies one sample per cycle with no back-pressure; sample_valid_out is a one-cycle strobe.
interface psola_playback_buffer_if;
  import psola_pkg::*;

  logic [DATA_W-1:0] win_val_in;
  win_addr_t         win_addr_in;
  logic              win_valid_in;
  logic              win_done_in;
  logic              sample_tick_in;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid_out;
  logic              underrun_out;
  logic              overflow_out;
  logic [1:0]        banks_full_out;
  rd_state_t         rd_state_out;

  modport master (
    output win_val_in, win_addr_in, win_valid_in, win_done_in, sample_tick_in,
    input  sample_out, sample_valid_out, underrun_out, overflow_out, banks_full_out, rd_state_out
  );

  modport slave (
    input  win_val_in, win_addr_in, win_valid_in, win_done_in, sample_tick_in,
    output sample_out, sample_valid_out, underrun_out, overflow_out, banks_full_out, rd_state_out
  );

endinterface

// File: rtl/pipeline.sv
// Fixed-depth register delay line with asynchronous clear.
module pipeline #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= data_in;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_out = stage_q[STAGES-1];

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// True dual-port, read-first, single-clock block RAM with optional output register.
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int RAM_WIDTH       = 18,
  parameter int RAM_DEPTH       = 1024,
  parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic [RAM_WIDTH-1:0]         dinb,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         web,
  input  logic                         ena,
  input  logic                         enb,
  input  logic                         rsta,
  input  logic                         rstb,
  input  logic                         regcea,
  input  logic                         regceb,
  output logic [RAM_WIDTH-1:0]         douta,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_a;
  logic [RAM_WIDTH-1:0] ram_data_b;

  always_ff @(posedge clka) begin
    if (ena && wea) bram[addra] <= dina;
    if (enb && web) bram[addrb] <= dinb;
  end

  always_ff @(posedge clka) begin
    if (ena) ram_data_a <= bram[addra];
    if (enb) ram_data_b <= bram[addrb];
  end

  generate
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
      assign douta = ram_data_a;
      assign doutb = ram_data_b;
    end else begin : g_out_reg
      always_ff @(posedge clka) begin
        if (rsta)        douta <= '0;
        else if (regcea) douta <= ram_data_a;
        if (rstb)        doutb <= '0;
        else if (regceb) doutb <= ram_data_b;
      end
    end
  endgenerate

endmodule

// File: rtl/psola_playback_buffer.sv
// Ping-pong capture of PSOLA window bursts and audio-rate replay of completed banks.
// Writer only ever sets the full bit of the non-full bank; reader only clears the one it drains.
module psola_playback_buffer
  import psola_pkg::*;
(
  input logic                     clk_in,
  input logic                     rst_in,
  psola_playback_buffer_if.slave  bus
);

  logic       wr_bank_q, wr_bank_d;
  logic [1:0] full_q, full_d;
  win_addr_t  max_addr_q, max_addr_d;
  logic       seen_q, seen_d;
  logic       done_prev_q;
  logic       overflow_q, overflow_d;
  win_addr_t  len_q [2];
  win_addr_t  len_d [2];
  rd_state_t  state_q, state_d;
  logic       rd_bank_q, rd_bank_d;
  win_addr_t  rd_ptr_q, rd_ptr_d;

  logic       wr_ok, done_edge, close_win, seen_eff;
  win_addr_t  max_eff;
  logic       serve, underrun_tick, last_rd;

  always_comb begin
    wr_ok     = bus.win_valid_in && (bus.win_addr_in < ADDR_W'(MAX_EXTENDED)) && !full_q[wr_bank_q];
    done_edge = bus.win_done_in && !done_prev_q;
    // A write landing in the same cycle as the done edge still counts toward length.
    max_eff   = (wr_ok && (bus.win_addr_in > max_addr_q)) ? bus.win_addr_in : max_addr_q;
    seen_eff  = seen_q || wr_ok;
    close_win = done_edge && seen_eff;

    serve         = bus.sample_tick_in && full_q[rd_bank_q];
    underrun_tick = bus.sample_tick_in && !full_q[rd_bank_q];
    last_rd       = serve && (rd_ptr_q == len_q[rd_bank_q] - ADDR_W'(1));

    overflow_d = bus.win_valid_in && !wr_ok;
    wr_bank_d  = wr_bank_q;
    max_addr_d = max_eff;
    seen_d     = seen_eff;
    len_d      = len_q;
    full_d     = full_q;
    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    rd_ptr_d   = rd_ptr_q;

    if (close_win) begin
      len_d[wr_bank_q]  = max_eff + ADDR_W'(1);
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
      max_addr_d        = '0;
      seen_d            = 1'b0;
    end

    if (serve) begin
      if (last_rd) begin
        full_d[rd_bank_q] = 1'b0;
        rd_ptr_d          = '0;
        rd_bank_d         = !rd_bank_q;
        state_d           = full_q[!rd_bank_q] ? PLAY : IDLE;
      end else begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        state_d  = PLAY;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      max_addr_q  <= '0;
      seen_q      <= 1'b0;
      done_prev_q <= 1'b0;
      overflow_q  <= 1'b0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      max_addr_q  <= max_addr_d;
      seen_q      <= seen_d;
      done_prev_q <= bus.win_done_in;
      overflow_q  <= overflow_d;
      len_q       <= len_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  logic [DATA_W-1:0] bram_douta_unused;
  logic [DATA_W-1:0] bram_doutb;
  logic [1:0]        pipe_out;

  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH       (DATA_W),
    .RAM_DEPTH       (2 * MAX_EXTENDED),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
  ) u_bram (
    .addra  (mem_addr(wr_bank_q, bus.win_addr_in)),
    .addrb  (mem_addr(rd_bank_q, rd_ptr_q)),
    .dina   (bus.win_val_in),
    .dinb   ('0),
    .clka   (clk_in),
    .wea    (1'b1),
    .web    (1'b0),
    .ena    (wr_ok),
    .enb    (1'b1),
    .rsta   (1'b0),
    .rstb   (1'b0),
    .regcea (1'b0),
    .regceb (1'b1),
    .douta  (bram_douta_unused),
    .doutb  (bram_doutb)
  );

  // Matches the two-register BRAM read path so strobes line up with data.
  pipeline #(
    .STAGES (2),
    .WIDTH  (2)
  ) u_valid_pipe (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  ({bus.sample_tick_in, underrun_tick}),
    .data_out (pipe_out)
  );

  assign bus.sample_valid_out = pipe_out[1];
  assign bus.underrun_out     = pipe_out[0];
  assign bus.sample_out       = (pipe_out[1] && !pipe_out[0]) ? bram_doutb : '0;
  assign bus.overflow_out     = overflow_q;
  assign bus.banks_full_out   = full_q;
  assign bus.rd_state_out     = state_q;

endmodule

// File: tb/tb_psola_playback_buffer.sv
// Directed bench for psola_playback_buffer: table of window scenarios plus
// hand sequences for out-of-order writes and reset during playback.
module tb_psola_playback_buffer;
  import psola_pkg::*;

  logic clk;
  logic rst;
  psola_playback_buffer_if bus();

  psola_playback_buffer dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  int ovf_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  always @(negedge clk) if (bus.overflow_out) ovf_cnt++;

  typedef struct {
    int         nwin;
    int         len_a, len_b, len_c;
    int         base_a, base_b, base_c;
    logic       dwl;       // last write coincides with done rising edge
    logic [1:0] exp_full;  // banks_full after all windows sent
    int         exp_ovf;   // overflow pulses expected
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    bus.sample_tick_in = 1'b0;
    bus.win_valid_in = 1'b0;
    bus.win_done_in = 1'b0;
    bus.win_val_in = '0;
    bus.win_addr_in = '0;
    #3;
    check("rst_sample", 64'(bus.sample_out), 0);
    check("rst_valid", 64'(bus.sample_valid_out), 0);
    check("rst_underrun", 64'(bus.underrun_out), 0);
    check("rst_overflow", 64'(bus.overflow_out), 0);
    check("rst_full", 64'(bus.banks_full_out), 0);
    check("rst_state", 64'(bus.rd_state_out), 64'(IDLE));
    ovf_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic write_one(input int addr, input int val, input logic with_done);
    @(posedge clk); #1;
    bus.win_valid_in = 1'b1;
    bus.win_addr_in  = ADDR_W'(addr);
    bus.win_val_in   = DATA_W'(val);
    if (with_done) bus.win_done_in = 1'b1;
  endtask

  task automatic finish_window();
    @(posedge clk); #1;
    bus.win_valid_in = 1'b0;
    bus.win_done_in  = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.win_done_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic write_window(input int base, input int len, input logic dwl);
    for (int i = 0; i < len; i++) write_one(i, base + i, dwl && (i == len - 1));
    finish_window();
  endtask

  task automatic do_tick(input logic exp_under, input logic [DATA_W-1:0] exp_val);
    @(posedge clk); #1 bus.sample_tick_in = 1'b1;
    @(posedge clk); #1 bus.sample_tick_in = 1'b0;
    check("pre_valid", 64'(bus.sample_valid_out), 0);
    @(posedge clk); #1;
    check("valid", 64'(bus.sample_valid_out), 1);
    check("underrun", 64'(bus.underrun_out), 64'(exp_under));
    check("sample", 64'(bus.sample_out), 64'(exp_val));
    @(posedge clk); #1;
    check("post_valid", 64'(bus.sample_valid_out), 0);
  endtask

  function automatic int len_of(input vec_t v, input int k);
    return (k == 0) ? v.len_a : (k == 1) ? v.len_b : v.len_c;
  endfunction

  function automatic int base_of(input vec_t v, input int k);
    return (k == 0) ? v.base_a : (k == 1) ? v.base_b : v.base_c;
  endfunction

  // ---------------- test body ----------------
  initial begin
    rst = 1'b1;
    bus.sample_tick_in = 1'b0;
    bus.win_valid_in = 1'b0;
    bus.win_done_in = 1'b0;
    bus.win_val_in = '0;
    bus.win_addr_in = '0;

    //            nwin lenA  lenB  lenC baseA baseB  baseC dwl   full   ovf
    vecs[0] = '{1,  100,  0,    0,  1000, 0,     0,    1'b0, 2'b01, 0};
    vecs[1] = '{0,  0,    0,    0,  0,    0,     0,    1'b0, 2'b00, 0};
    vecs[2] = '{2,  50,   70,   0,  2000, 3000,  0,    1'b1, 2'b11, 0};
    vecs[3] = '{3,  40,   30,   20, 4000, 5000,  6000, 1'b0, 2'b11, 20};
    vecs[4] = '{2,  1,    2200, 0,  7000, 10000, 0,    1'b1, 2'b11, 0};

    for (int s = 0; s < 5; s++) begin
      int nplay;
      do_reset();
      for (int k = 0; k < vecs[s].nwin; k++)
        write_window(base_of(vecs[s], k), len_of(vecs[s], k), vecs[s].dwl);
      check("full_after_write", 64'(bus.banks_full_out), 64'(vecs[s].exp_full));
      check("ovf_count", 64'(ovf_cnt), 64'(vecs[s].exp_ovf));
      exp_q.delete();
      for (int k = 0; k < vecs[s].nwin && k < 2; k++)
        for (int i = 0; i < len_of(vecs[s], k); i++)
          exp_q.push_back(DATA_W'(base_of(vecs[s], k) + i));
      nplay = exp_q.size();
      for (int t = 0; t < nplay; t++) begin
        do_tick(1'b0, exp_q.pop_front());
        if (t == 0) check("state_play", 64'(bus.rd_state_out), 64'(PLAY));
        if (t == vecs[s].len_a - 1 && vecs[s].nwin >= 2)
          check("full_mid", 64'(bus.banks_full_out), 2);
      end
      check("full_end", 64'(bus.banks_full_out), 0);
      check("state_idle", 64'(bus.rd_state_out), 64'(IDLE));
      for (int u = 0; u < 3; u++) do_tick(1'b1, '0);
    end

    // Out-of-range write, reversed addresses, duplicate of addr 10.
    do_reset();
    write_one(2200, 1, 1'b0);
    @(posedge clk); #1 bus.win_valid_in = 1'b0;
    @(posedge clk); #1;
    check("ovf_out_of_range", 64'(ovf_cnt), 1);
    check("full_out_of_range", 64'(bus.banks_full_out), 0);
    for (int a = 99; a >= 0; a--) write_one(a, 5000 + a, 1'b0);
    write_one(10, 7777, 1'b0);
    finish_window();
    check("ooo_full", 64'(bus.banks_full_out), 1);
    check("ooo_ovf", 64'(ovf_cnt), 1);
    for (int i = 0; i < 100; i++) do_tick(1'b0, (i == 10) ? DATA_W'(7777) : DATA_W'(5000 + i));
    do_tick(1'b1, '0);

    // Reset during playback with a tick in flight.
    do_reset();
    write_window(100, 200, 1'b0);
    for (int i = 0; i < 50; i++) do_tick(1'b0, DATA_W'(100 + i));
    @(posedge clk); #1 bus.sample_tick_in = 1'b1;
    @(posedge clk); #1 bus.sample_tick_in = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.sample_valid_out), 0);
    check("midrst_sample", 64'(bus.sample_out), 0);
    check("midrst_full", 64'(bus.banks_full_out), 0);
    check("midrst_state", 64'(bus.rd_state_out), 64'(IDLE));
    @(posedge clk); #1 rst = 1'b0;
    begin
      int stray = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (bus.sample_valid_out) stray++;
      end
      check("post_rst_no_valid", 64'(stray), 0);
    end
    do_tick(1'b1, '0);
    write_window(9000, 10, 1'b0);
    for (int i = 0; i < 10; i++) do_tick(1'b0, DATA_W'(9000 + i));
    do_tick(1'b1, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
